// File: rtl/wave_capture_multi.sv
// wave_capture_multi: NUM_CH-channel ping-pong capture buffer for a wave display.
// Signed samples are stored offset-binary, with trigger modes and decimation.
// Ports:
//   clk, reset            clock, async active-high reset
//   new_sample, sample    sample strobe and packed signed channel bus
//   trig_mode, trig_ch    0/3 free-run, 1 rising, 2 falling; watched channel
//   decim                 keep one of every decim+1 strobes
//   display_idle          display blanking; allows the buffer swap
//   rd_addr, rd_ch        display read address and channel
//   rd_data               registered read data (1-cycle latency)
//   rd_index              buffer half owned by the display
//   capturing             high while capturing a frame
//   frame_done            one-cycle pulse on buffer swap
module wave_capture_multi #(
   parameter int SAMPLE_W   = 18,
   parameter int OUT_W      = 8,
   parameter int DEPTH_LOG2 = 9,
   parameter int NUM_CH     = 2,
   parameter int CH_W       = 1,
   parameter int DECIM_W    = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       new_sample,
   input  logic [NUM_CH*SAMPLE_W-1:0] sample,
   input  logic [1:0]                 trig_mode,
   input  logic [CH_W-1:0]            trig_ch,
   input  logic [DECIM_W-1:0]         decim,
   input  logic                       display_idle,
   input  logic [DEPTH_LOG2-1:0]      rd_addr,
   input  logic [CH_W-1:0]            rd_ch,
   output logic [OUT_W-1:0]           rd_data,
   output logic                       rd_index,
   output logic                       capturing,
   output logic                       frame_done
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {
      ARM,
      WAIT_TRIG,
      CAPTURE,
      WAIT_IDLE
   } state_t;

   state_t                state_q, state_d;
   logic [DEPTH_LOG2-1:0] count_q, count_d;
   logic [DECIM_W-1:0]    dcnt_q, dcnt_d;
   logic [DECIM_W-1:0]    decim_q, decim_d;
   logic [1:0]            mode_q, mode_d;
   logic                  prev_neg_q, prev_neg_d;
   logic                  rd_index_q, rd_index_d;
   logic                  frame_done_q, frame_done_d;
   logic                  rd_ok_q, rd_ok_d;
   logic [CH_W-1:0]       rd_sel_q;

   logic                  kept;
   logic                  cur_neg;
   logic                  free_in;
   logic                  hit;
   logic                  we;
   logic [DEPTH_LOG2:0]   waddr;
   logic [DEPTH_LOG2:0]   raddr;
   logic [OUT_W-1:0]      rdw [NUM_CH];

   // Offset binary: top bits with the sign bit inverted.
   function automatic logic [OUT_W-1:0] to_disp(input logic [OUT_W-1:0] top);
      to_disp = top;
      to_disp[OUT_W-1] = ~top[OUT_W-1];
   endfunction

   // The trigger conditions only look at sign, so only the sign of the
   // previous kept trigger sample is retained.
   always_comb begin
      cur_neg = sample[SAMPLE_W-1];
      for (int c = 1; c < NUM_CH; c++) begin
         if (trig_ch == c[CH_W-1:0]) cur_neg = sample[c*SAMPLE_W+SAMPLE_W-1];
      end
   end

   assign kept    = new_sample && (dcnt_q == decim_q);
   assign free_in = (trig_mode == 2'd0) || (trig_mode == 2'd3);
   assign hit     = ((mode_q == 2'd1) && prev_neg_q && !cur_neg) ||
                    ((mode_q == 2'd2) && !prev_neg_q && cur_neg);

   // count is zero in ARM and WAIT_TRIG, so the trigger write lands at 0.
   assign waddr = {~rd_index_q, count_q};
   assign raddr = {rd_index_q, rd_addr};

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      dcnt_d       = dcnt_q;
      decim_d      = decim_q;
      mode_d       = mode_q;
      prev_neg_d   = prev_neg_q;
      rd_index_d   = rd_index_q;
      frame_done_d = 1'b0;
      we           = 1'b0;

      if (new_sample) dcnt_d = kept ? '0 : dcnt_q + 1'b1;
      if (kept) prev_neg_d = cur_neg;

      unique case (state_q)
         ARM: begin
            if (kept) begin
               decim_d = decim;
               mode_d  = trig_mode;
               if (free_in) begin
                  we      = 1'b1;
                  count_d = count_q + 1'b1;
                  state_d = CAPTURE;
               end else begin
                  state_d = WAIT_TRIG;
               end
            end
         end
         WAIT_TRIG: begin
            if (kept && hit) begin
               we      = 1'b1;
               count_d = count_q + 1'b1;
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            if (kept) begin
               we      = 1'b1;
               count_d = count_q + 1'b1;
               if (&count_q) state_d = WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            // A strobe in the swap cycle is dropped and not counted.
            if (display_idle) begin
               rd_index_d   = ~rd_index_q;
               frame_done_d = 1'b1;
               dcnt_d       = '0;
               state_d      = ARM;
            end
         end
      endcase
   end

   always_comb begin
      rd_ok_d = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (rd_ch == c[CH_W-1:0]) rd_ok_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ARM;
         count_q      <= '0;
         dcnt_q       <= '0;
         decim_q      <= '0;
         mode_q       <= '0;
         prev_neg_q   <= 1'b0;
         rd_index_q   <= 1'b0;
         frame_done_q <= 1'b0;
         rd_ok_q      <= 1'b0;
         rd_sel_q     <= '0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         dcnt_q       <= dcnt_d;
         decim_q      <= decim_d;
         mode_q       <= mode_d;
         prev_neg_q   <= prev_neg_d;
         rd_index_q   <= rd_index_d;
         frame_done_q <= frame_done_d;
         rd_ok_q      <= rd_ok_d;
         rd_sel_q     <= rd_ch;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [OUT_W-1:0] mem [2*DEPTH];
      logic [OUT_W-1:0] rdw_q;
      logic [OUT_W-1:0] top;
      logic             unused_lsb;

      assign top = sample[g*SAMPLE_W+SAMPLE_W-1 -: OUT_W];
      // Bits below the stored precision are intentionally discarded.
      assign unused_lsb = ^sample[g*SAMPLE_W +: SAMPLE_W-OUT_W];

      always_ff @(posedge clk) begin
         if (we) mem[waddr] <= to_disp(top);
         rdw_q <= mem[raddr];
      end

      assign rdw[g] = rdw_q;
   end

   always_comb begin
      rd_data = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (rd_ok_q && (rd_sel_q == c[CH_W-1:0])) rd_data = rdw[c];
      end
   end

   assign rd_index   = rd_index_q;
   assign frame_done = frame_done_q;
   assign capturing  = (state_q == CAPTURE);

endmodule
